// File: rtl/mux41_arbiter.sv
// 4:1 mux with a round-robin, hold-limited arbiter choosing the select.
// A requester keeps the grant while it requests, up to MAX_HOLD cycles.
// On release the next requester after the current one wins on the same
// edge. The data path registers d[s] behind the registered grant.
//
// state | meaning
// IDLE  | no grant outstanding, gnt = 0000
// GRANT | exactly one gnt bit high, hold_cnt counts its cycles
module mux41_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       y,
  output logic       y_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       y_q, y_d;
  logic       y_valid_q, y_valid_d;

  logic [1:0] base;
  logic       found;
  logic [1:0] win;

  // First set request after 'b' in round-robin order; 'b' itself is
  // checked last so a sole requester can be regranted.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] b);
    logic       f;
    logic [1:0] w;
    logic [1:0] idx;
    f = 1'b0;
    w = 2'd0;
    // Scan farthest-first so the nearest set bit is the last assignment.
    for (int i = 4; i >= 1; i--) begin
      idx = b + 2'(i);
      if (r[idx]) begin
        f = 1'b1;
        w = idx;
      end
    end
    return {f, w};
  endfunction

  // Round-robin search result for this edge.
  always_comb begin
    base = (state_q == GRANT) ? s_q : last_q;
    {found, win} = rr_pick(req, base);
  end

  // Next-state, grant, hold counter and data-path computation.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    last_d    = last_q;
    hold_d    = hold_q;
    y_d       = 1'b0;
    y_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          s_d     = win;
          last_d  = win;
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        if (req[s_q] && (hold_q < MAX_HOLD_C)) begin
          hold_d = hold_q + 4'd1;
        end else if (found) begin
          gnt_d  = 4'b0001 << win;
          s_d    = win;
          last_d = win;
          hold_d = 4'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          hold_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase

    if (gnt_q != 4'b0000) begin
      y_d       = d[s_q];
      y_valid_d = 1'b1;
    end
  end

  // State register; pointer resets to 3 so requester 0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      s_q       <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= 4'd0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign s       = s_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux41_arbiter.sv
// Directed bench for mux41_arbiter (MAX_HOLD = 4). Each step drives req/d
// on a falling edge and queues the hand-computed outputs expected after the
// next rising edge; the monitor pops and compares after every rising edge.
module tb_mux41_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       y;
    logic       yv;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       y_valid;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;
  int   step_no;

  mux41_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .s       (s),
    .y       (y),
    .y_valid (y_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_now(input string name, input exp_t e);
    exp_t a;
    a = '{gnt: gnt, s: s, y: y, yv: y_valid};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b s=%0d y=%b y_valid=%b, want gnt=%b s=%0d y=%b y_valid=%b",
               name, a.gnt, a.s, a.y, a.yv, e.gnt, e.s, e.y, e.yv);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] dd,
                      input logic [3:0] g, input logic [1:0] ss,
                      input logic yy, input logic vv);
    @(negedge clk);
    req = r;
    d   = dd;
    exp_q.push_back('{gnt: g, s: ss, y: yy, yv: vv});
  endtask

  // Monitor: one registered output set per rising edge.
  initial begin
    exp_t e;
    step_no = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        check_now($sformatf("edge%0d", step_no), e);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    #1;
    check_now("reset_init", '{gnt: 4'b0000, s: 2'd0, y: 1'b0, yv: 1'b0});
    #2 rst_n = 1'b1;

    // Sole requester 2: regranted every MAX_HOLD cycles with no gap.
    step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);

    // Asynchronous reset mid-grant.
    @(negedge clk);
    check_now("pre_reset_grant", '{gnt: 4'b0100, s: 2'd2, y: 1'b1, yv: 1'b1});
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check_now("async_reset", '{gnt: 4'b0000, s: 2'd0, y: 1'b0, yv: 1'b0});
    #2 rst_n = 1'b1;
    #1;
    check_now("post_release", '{gnt: 4'b0000, s: 2'd0, y: 1'b0, yv: 1'b0});
    exp_q.push_back('{gnt: 4'b0000, s: 2'd0, y: 1'b0, yv: 1'b0});

    // All four requesting: 4 cycles each, in order 0,1,2,3,0.
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b0, 1'b1);
    step(4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1);

    // Requester 0 drops: grant moves to 1; then req[1] drops after 2 cycles.
    step(4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b0, 1'b1);
    step(4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b0, 1'b1);
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b1);
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);

    // Grant to 3 expires with req=1001: wrap to 0, then back to 3.
    step(4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);

    // All requests withdrawn: grant clears, y_valid falls one edge later.
    step(4'b0000, 4'b1001, 4'b0000, 2'd3, 1'b1, 1'b1);
    step(4'b0000, 4'b1001, 4'b0000, 2'd3, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);

    // From idle with pointer at 3: search starts at 0, first hit is 1.
    step(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
    step(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux41_arbiter.md
MUX41_ARBITER -- requirements
Module: mux41_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles of one grant (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4 bits: request lines, where req[k] is requester k.
REQ-005 SHALL have port d, input, 4 bits: per-requester data, where d[k] feeds mux input i_k.
REQ-006 SHALL have port gnt, output, 4 bits: registered grant, one-hot or all-zero.
REQ-007 SHALL have port s, output, 2 bits: registered mux select, equal to the index of the current or last grant.
REQ-008 SHALL have port y, output, 1 bit: registered mux output, d[s] delayed one cycle.
REQ-009 SHALL have port y_valid, output, 1 bit: high when y carries granted data.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-011 SHALL keep a 2-bit last-grant pointer; the search order starts at last+1 and wraps mod 4 (3 -> 0).
REQ-012 SHALL, in IDLE on an edge where req != 0, select the first set req bit in search order, load gnt/s with it, set hold_cnt=1, and enter GRANT; gnt is visible the cycle after req is sampled.
REQ-013 SHALL, in IDLE on an edge where req == 0, stay in IDLE with gnt=0000 and s unchanged.
REQ-014 SHALL, in GRANT, keep the grant and increment hold_cnt when req[s]=1 and hold_cnt < MAX_HOLD.
REQ-015 SHALL release the grant when req[s]=0 or hold_cnt == MAX_HOLD; both conditions on the same edge SHALL count as a single release.
REQ-016 SHALL, on release, re-arbitrate on that same edge over the current req in search order from s+1, with no idle bubble between grants.
REQ-017 SHALL, on release with a winner, update gnt/s/pointer and set hold_cnt=1; if the winner is the same requester (sole requester), SHALL regrant it with gnt unchanged and hold_cnt reset to 1.
REQ-018 SHALL, on release with req == 0, go to IDLE and clear gnt to 0000; s and the pointer SHALL hold.
REQ-019 SHALL, on every edge where gnt != 0, register y <= d[s] and y_valid <= 1; otherwise y <= 0 and y_valid <= 0.
REQ-020 SHALL never have more than one gnt bit high, and SHALL ignore req changes on non-granted lines until the next arbitration edge.
REQ-021 SHALL size hold_cnt at 4 bits; it SHALL saturate at MAX_HOLD and never wrap.

Reset
REQ-022 SHALL, while rst_n=0 (immediately, without waiting for clk), force state=IDLE, gnt=0000, s=00, pointer=3, hold_cnt=0, y=0, y_valid=0.
REQ-023 SHALL, when reset is asserted mid-grant, drop the grant at once; after release, the first arbitration SHALL favour requester 0.
REQ-024 SHALL leave outputs at their reset values until the first rising clk edge after rst_n goes high.

Verification (MAX_HOLD=4)
REQ-025 SHALL cover: rst_n pulsed low mid-grant with gnt=0100 -> outputs are 0000/00/0/0 before the next edge; then req=1111 -> first gnt=0001.
REQ-026 SHALL cover: req=0100 held 10 cycles with d=0100 -> gnt=0100 continuously, hold_cnt 1,2,3,4,1,2,..., y=1 and y_valid=1 from the second grant cycle.
REQ-027 SHALL cover: req=1111 held -> gnt 0001,0010,0100,1000 for 4 cycles each, cyclic, no zero cycles; s tracks 0,1,2,3.
REQ-028 SHALL cover: gnt=0010 with req=1010, then req[1] drops after 2 granted cycles -> gnt=1000 on the next edge; y follows d[3] one cycle later.
REQ-029 SHALL cover: req goes to 0000 during a grant -> gnt=0000 on the next edge, y_valid=0 one edge later, s unchanged.
REQ-030 SHALL cover: after a grant to 3 expires with req=1001 -> next gnt=0001 (wrap-around), then 1000 after that grant releases.
